// File: rtl/pipe_pkg.sv
// Shared definitions for the EX->DM pipeline stage.
//
// Holds the default field widths and reset PC, plus the reference bundle layout.
// A bundle is packed MSB..LSB as {err, halt, memread, memwrt, alu, pc, rtdata}.
// The stage itself is parametrised, so it packs bundles as flat vectors in the
// same order and sizes them with bundle_w().
package pipe_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;
    localparam int CTRL_W     = 4;

    localparam logic [ADDR_W_DEF-1:0] RST_PC_DEF = 16'h0000;

    // Reference layout at default widths.
    typedef struct packed {
        logic                  err;
        logic                  halt;
        logic                  memread;
        logic                  memwrt;
        logic [DATA_W_DEF-1:0] alu;
        logic [ADDR_W_DEF-1:0] pc;
        logic [DATA_W_DEF-1:0] rtdata;
    } exdm_bundle;

    // Total packed width of one bundle for the given field widths.
    function automatic int bundle_w(input int data_w, input int addr_w);
        return (2 * data_w) + addr_w + CTRL_W;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One bundle register of the EX->DM stage.
//
// Ports:
//   clk   in   rising-edge clock
//   clr   in   synchronous clear to RST_VAL (wins over load)
//   load  in   capture d on this edge
//   d     in   W-bit bundle to capture
//   q     out  W-bit held bundle
module pipe_slot #(
    parameter int          W       = 1,
    parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Bundle register: clear has priority, otherwise load or hold.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/exdm_pipe_stage.sv
// EX->DM pipeline stage with valid/ready flow control, stall and flush.
//
// Carries ALU result, store data, PC and memory/halt/error control from the
// execute stage to data memory with one cycle of latency.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    squash held ops and the op offered this cycle
//   in_valid / in_ready      EX-side handshake
//   in_rtdata/pc/alu         payload from EX
//   in_memwrt/memread/halt/err control from EX
//   out_valid / out_ready    DM-side handshake
//   out_rtdata/pc/alu        registered payload
//   out_memwrt/memread/halt/err registered control, gated by out_valid
//
// Build option: EXDM_SKID_EN adds a second (skid) slot and makes in_ready
// depend only on registered state; without it a single slot is used and
// in_ready follows out_ready combinationally.
module exdm_pipe_stage
    import pipe_pkg::*;
#(
    parameter int                DATA_W = DATA_W_DEF,
    parameter int                ADDR_W = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RST_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_rtdata,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_alu,
    input  logic              in_memwrt,
    input  logic              in_memread,
    input  logic              in_halt,
    input  logic              in_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rtdata,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_alu,
    output logic              out_memwrt,
    output logic              out_memread,
    output logic              out_halt,
    output logic              out_err
);

    localparam int BW = bundle_w(DATA_W, ADDR_W);
    localparam logic [BW-1:0] RST_BUNDLE = {4'b0000, {DATA_W{1'b0}}, RST_PC, {DATA_W{1'b0}}};

    logic [BW-1:0] in_bundle;
    logic [BW-1:0] main_d;
    logic [BW-1:0] main_q;
    logic          main_valid;
    logic          main_load;
    logic          accept;
    logic          xfer;
    logic          clr;

    assign in_bundle = {in_err, in_halt, in_memread, in_memwrt, in_alu, in_pc, in_rtdata};
    assign clr       = rst | flush;
    // Flush drops the offered op even when the handshake completes.
    assign accept    = in_valid & in_ready & ~flush;
    assign xfer      = main_valid & out_ready;

`ifdef EXDM_SKID_EN
    logic [BW-1:0] skid_q;
    logic          skid_valid;
    logic          skid_load;

    // skid_valid is a register, so in_ready has no path from out_ready.
    assign in_ready = ~skid_valid;

    // Slot steering: on transfer, refill main from skid (order kept) or from EX;
    // an op arriving while main is stalled parks in the skid slot.
    always_comb begin
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = in_bundle;
        if (xfer) begin
            main_load = skid_valid | accept;
            main_d    = skid_valid ? skid_q : in_bundle;
        end else if (!main_valid) begin
            main_load = accept;
        end else begin
            skid_load = accept;
        end
    end

    // Occupancy bits for both slots.
    always_ff @(posedge clk) begin
        if (clr) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            main_valid <= main_load | (main_valid & ~xfer);
            skid_valid <= skid_load | (skid_valid & ~xfer);
        end
    end

    pipe_slot #(.W(BW), .RST_VAL(RST_BUNDLE)) u_skid (
        .clk  (clk),
        .clr  (clr),
        .load (skid_load),
        .d    (in_bundle),
        .q    (skid_q)
    );
`else
    // Single slot frees up in the same cycle DM consumes it.
    assign in_ready  = ~main_valid | out_ready;
    assign main_load = accept;
    assign main_d    = in_bundle;

    // Occupancy bit for the single slot.
    always_ff @(posedge clk) begin
        if (clr) begin
            main_valid <= 1'b0;
        end else begin
            main_valid <= main_load | (main_valid & ~xfer);
        end
    end
`endif

    pipe_slot #(.W(BW), .RST_VAL(RST_BUNDLE)) u_main (
        .clk  (clk),
        .clr  (clr),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    assign out_valid   = main_valid;
    assign out_rtdata  = main_q[DATA_W-1:0];
    assign out_pc      = main_q[DATA_W +: ADDR_W];
    assign out_alu     = main_q[DATA_W+ADDR_W +: DATA_W];
    // An empty slot must never issue a memory op, so control is gated.
    assign out_memwrt  = main_valid & main_q[BW-4];
    assign out_memread = main_valid & main_q[BW-3];
    assign out_halt    = main_valid & main_q[BW-2];
    assign out_err     = main_valid & main_q[BW-1];

endmodule

// File: tb/tb_exdm_pipe_stage.sv
// Self-checking bench for exdm_pipe_stage: directed stimulus, queue scoreboard
// filled on accepted ops, and a negedge monitor that checks every presented op.
module tb_exdm_pipe_stage;

    localparam logic [15:0] RPC = 16'h0100;

    typedef struct packed {
        logic        err;
        logic        halt;
        logic        memread;
        logic        memwrt;
        logic [15:0] alu;
        logic [15:0] pc;
        logic [15:0] rt;
    } op_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_rtdata = 16'h0000;
    logic [15:0] in_pc = 16'h0000;
    logic [15:0] in_alu = 16'h0000;
    logic        in_memwrt = 1'b0;
    logic        in_memread = 1'b0;
    logic        in_halt = 1'b0;
    logic        in_err = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_rtdata;
    logic [15:0] out_pc;
    logic [15:0] out_alu;
    logic        out_memwrt;
    logic        out_memread;
    logic        out_halt;
    logic        out_err;

    int   total = 0;
    int   bad = 0;
    int   occ = 0;
    logic mon_en = 1'b0;
    logic last_acc = 1'b0;
    op_t  cur;
    op_t  scb[$];

    exdm_pipe_stage #(.DATA_W(16), .ADDR_W(16), .RST_PC(RPC)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rtdata(in_rtdata), .in_pc(in_pc), .in_alu(in_alu),
        .in_memwrt(in_memwrt), .in_memread(in_memread), .in_halt(in_halt), .in_err(in_err),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rtdata(out_rtdata), .out_pc(out_pc), .out_alu(out_alu),
        .out_memwrt(out_memwrt), .out_memread(out_memread), .out_halt(out_halt), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic op_t mk(input logic [15:0] alu, input logic [15:0] pc,
                               input logic [15:0] rt, input logic [3:0] ctl);
        return op_t'({ctl, alu, pc, rt});
    endfunction

    task automatic drive(input op_t o, input logic v);
        cur        = o;
        in_valid   = v;
        in_err     = o.err;
        in_halt    = o.halt;
        in_memread = o.memread;
        in_memwrt  = o.memwrt;
        in_alu     = o.alu;
        in_pc      = o.pc;
        in_rtdata  = o.rt;
    endtask

    // One clock: predict ready/accept from an occupancy model, update the
    // scoreboard, then return 1 time unit after the rising edge.
    task automatic step();
        logic er;
        logic acc;
        logic xf;
        @(negedge clk);
        #1;
`ifdef EXDM_SKID_EN
        er = (occ < 2);
`else
        er = (occ == 0) || out_ready;
`endif
        if (!rst) chk("in_ready", {63'd0, in_ready}, {63'd0, er});
        acc = in_valid && er && !flush && !rst;
        xf  = (occ > 0) && out_ready;
        if (rst || flush) begin
            scb.delete();
            occ = 0;
        end else begin
            if (acc) scb.push_back(cur);
            occ = occ + (acc ? 1 : 0) - (xf ? 1 : 0);
        end
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented op must match the scoreboard head.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid) begin
                if (scb.size() == 0) begin
                    chk("spurious_out", 64'd1, 64'd0);
                end else begin
                    chk("payload", {12'd0, out_err, out_halt, out_memread, out_memwrt,
                                    out_alu, out_pc, out_rtdata}, {12'd0, scb[0]});
                    if (out_ready) void'(scb.pop_front());
                end
            end else begin
                chk("gated_ctl", {60'd0, out_err, out_halt, out_memread, out_memwrt}, 64'd0);
                chk("missing_out", {32'd0, scb.size()}, 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t         a, b, e;
        logic [15:0] alu_tab [8];
        logic        b_taken;
        alu_tab = '{16'h1234, 16'h2345, 16'h3456, 16'h4567,
                    16'h5678, 16'h6789, 16'h789A, 16'h89AB};

        // 1: reset
        step();
        step();
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_pc", {48'd0, out_pc}, {48'd0, RPC});
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_memwrt", {63'd0, out_memwrt}, 64'd0);
        chk("rst_alu", {48'd0, out_alu}, 64'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // 2: streaming, 8 ops back to back
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(mk(alu_tab[i], 16'(16'h0010 + 2 * i), 16'(16'hA000 + i),
                     (i % 2 == 0) ? 4'b0001 : 4'b0010), 1'b1);
            step();
            if (i == 0) begin
                chk("first_alu", {48'd0, out_alu}, 64'h1234);
                chk("first_memwrt", {63'd0, out_memwrt}, 64'd1);
            end
        end
        in_valid = 1'b0;
        step();
        step();

        // 3: stall with B offered
        out_ready = 1'b0;
        a = mk(16'hAAAA, 16'h0200, 16'h0A0A, 4'b0001);
        b = mk(16'hBBBB, 16'h0202, 16'h0B0B, 4'b0010);
        drive(a, 1'b1);
        step();
        chk("a_loaded", {48'd0, out_alu}, 64'hAAAA);
        b_taken = 1'b0;
        drive(b, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            if (last_acc) begin
                b_taken  = 1'b1;
                in_valid = 1'b0;
            end
            chk("stall_hold", {48'd0, out_alu}, 64'hAAAA);
            chk("stall_ready", {63'd0, in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        step();
        chk("stall_idle_hold", {48'd0, out_alu}, 64'hAAAA);
        in_valid  = ~b_taken;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (last_acc) in_valid = 1'b0;
        end

        // 4: flush with full slot, DM stalled, then with DM ready
        out_ready = 1'b0;
        a = mk(16'hC0DE, 16'h0300, 16'h1111, 4'b0100);
        b = mk(16'hDEAD, 16'h0302, 16'h2222, 4'b0001);
        drive(a, 1'b1);
        step();
        drive(b, 1'b1);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_memread", {63'd0, out_memread}, 64'd0);
        chk("flush_pc", {48'd0, out_pc}, {48'd0, RPC});
        out_ready = 1'b1;
        drive(a, 1'b1);
        step();
        drive(b, 1'b1);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush2_valid", {63'd0, out_valid}, 64'd0);
        step();
        chk("flush2_empty", {63'd0, out_valid}, 64'd0);
        step();

        // 5: rst+flush mid-stall, then rst with both slots loaded
        out_ready = 1'b0;
        drive(mk(16'h3333, 16'h0500, 16'h3030, 4'b0001), 1'b1);
        step();
        drive(mk(16'h4444, 16'h0502, 16'h4040, 4'b0010), 1'b1);
        step();
        rst   = 1'b1;
        flush = 1'b1;
        step();
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("rstfl_valid", {63'd0, out_valid}, 64'd0);
        chk("rstfl_pc", {48'd0, out_pc}, {48'd0, RPC});
        chk("rstfl_alu", {48'd0, out_alu}, 64'd0);
        chk("rstfl_rt", {48'd0, out_rtdata}, 64'd0);
        chk("rstfl_ready", {63'd0, in_ready}, 64'd1);
        drive(mk(16'h5555, 16'h0600, 16'h5050, 4'b0001), 1'b1);
        step();
        drive(mk(16'h6666, 16'h0602, 16'h6060, 4'b0100), 1'b1);
        step();
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        chk("rst2_valid_a", {63'd0, out_valid}, 64'd0);
        step();
        chk("rst2_valid_b", {63'd0, out_valid}, 64'd0);
        chk("rst2_ready", {63'd0, in_ready}, 64'd1);

        // 6: err/halt op gated by valid
        out_ready = 1'b0;
        e = mk(16'hEEEE, 16'h0400, 16'h0E0E, 4'b1100);
        drive(e, 1'b1);
        step();
        in_valid = 1'b0;
        chk("eh_err", {63'd0, out_err}, 64'd1);
        chk("eh_halt", {63'd0, out_halt}, 64'd1);
        out_ready = 1'b1;
        step();
        chk("eh_err_after", {63'd0, out_err}, 64'd0);
        chk("eh_halt_after", {63'd0, out_halt}, 64'd0);
        chk("eh_valid_after", {63'd0, out_valid}, 64'd0);

        // drain, bounded
        for (int k = 0; k < 5; k++) begin
            if (scb.size() != 0) step();
        end
        chk("drain", {32'd0, scb.size()}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
